// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_sync.sv
// Two-flop synchroniser for the asynchronous SPI pins; reset value selectable
// so that chip select can come out of reset deasserted.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Metastability chain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/spi_regfile.sv
// Mode-0 SPI slave with a parametrised register bank; frames are checked before commit.
// Define SPI_REGFILE_READBACK_EN to build the sdo read-back path.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int                NUM_REGS  = 5,
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         sclk_i,
    input  logic                         cs_n_i,
    input  logic                         sdi_i,
    output logic                         sdo_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_stb_o,
    output logic [ADDR_W-1:0]            wr_addr_o,
    output logic                         frame_err_o
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic sclk_s, cs_n_s, sdi_s;
    logic sclk_prev_q, cs_n_prev_q;
    logic sclk_rise_s, cs_fall_s, cs_rise_s;

    state_e state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic               pend_q, pend_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               wr_stb_q, frame_err_q;
    logic [ADDR_W-1:0]  wr_addr_q;

    logic              start_s, shift_en_s, commit_s, err_s;
    logic              len_ok_s, addr_ok_s, f_rw_s;
    logic [ADDR_W-1:0] f_addr_s;
    logic [DATA_W-1:0] f_data_s;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i), .q_o(sclk_s));
    spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk_i(clk_i), .rst_i(rst_i), .d_i(cs_n_i), .q_o(cs_n_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_sdi  (.clk_i(clk_i), .rst_i(rst_i), .d_i(sdi_i),  .q_o(sdi_s));

    // Edge-detect history
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_n_prev_q <= cs_n_s;
        end
    end

    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign cs_fall_s   = ~cs_n_s & cs_n_prev_q;
    assign cs_rise_s   = cs_n_s & ~cs_n_prev_q;

    assign f_rw_s   = rx_q[FRAME_W-1];
    assign f_addr_s = rx_q[DATA_W +: ADDR_W];
    assign f_data_s = rx_q[DATA_W-1:0];
    assign len_ok_s  = (cnt_q == CNT_W'(FRAME_W));
    assign addr_ok_s = ({1'b0, f_addr_s} < NUM_REGS_W);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a rising chip select takes priority over any sclk edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_s ? SHIFT : IDLE;
            SHIFT:   state_d = cs_rise_s ? CHECK : SHIFT;
            CHECK:   state_d = (len_ok_s && addr_ok_s && (f_rw_s == RW_WRITE)) ? COMMIT : IDLE;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        start_s    = (state_q == IDLE) && (cs_fall_s || (pend_q && !cs_n_s));
        shift_en_s = (state_q == SHIFT) && sclk_rise_s && !cs_n_s;
        commit_s   = (state_q == COMMIT);
        err_s      = (state_q == CHECK) && (!len_ok_s || (!addr_ok_s && (f_rw_s == RW_WRITE)));
    end

    // Remember a chip-select fall that lands while a previous frame is being resolved
    always_comb begin
        pend_d = pend_q;
        if ((state_q == CHECK || state_q == COMMIT) && cs_fall_s) begin
            pend_d = 1'b1;
        end else if (state_q == IDLE) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Receive shift register and saturating bit counter
    always_comb begin
        cnt_d = cnt_q;
        rx_d  = rx_q;
        if (start_s) begin
            cnt_d = {CNT_W{1'b0}};
            rx_d  = {FRAME_W{1'b0}};
        end else if (shift_en_s) begin
            rx_d  = {rx_q[FRAME_W-2:0], sdi_s};
            cnt_d = (cnt_q == CNT_W'(FRAME_W + 1)) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
            rx_d  = rx_q;
        end
    end

    // Frame state, register bank and strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= {CNT_W{1'b0}};
            rx_q        <= {FRAME_W{1'b0}};
            pend_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            pend_q      <= pend_d;
            wr_stb_q    <= commit_s;
            frame_err_q <= err_s;
            if (commit_s) begin
                wr_addr_q <= f_addr_s;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && (f_addr_s == ADDR_W'(i))) begin
                    regs_q[i] <= f_data_s;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign frame_err_o = frame_err_q;

`ifdef SPI_REGFILE_READBACK_EN
    localparam int TXC_W = $clog2(DATA_W + 1);

    logic              sclk_fall_s, load_s;
    logic [ADDR_W:0]   hdr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              sdo_q, sdo_d;

    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    // rw plus address, including the bit arriving on this rise
    assign hdr_s  = {rx_q[ADDR_W-1:0], sdi_s};
    assign load_s = shift_en_s && (cnt_q == CNT_W'(ADDR_W)) && (hdr_s[ADDR_W] == RW_READ);

    // Read-data mux; out-of-range addresses return zero
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (hdr_s[ADDR_W-1:0] == ADDR_W'(i)) ? regs_q[i] : rd_data_s;
        end
    end

    // Transmit shifter: load after the header, shift one bit per sclk fall
    always_comb begin
        tx_d     = tx_q;
        tx_cnt_d = tx_cnt_q;
        sdo_d    = sdo_q;
        if (cs_n_s || (state_q != SHIFT)) begin
            tx_cnt_d = {TXC_W{1'b0}};
            sdo_d    = 1'b0;
        end else if (load_s) begin
            tx_d     = rd_data_s;
            tx_cnt_d = TXC_W'(DATA_W);
        end else if (sclk_fall_s) begin
            if (tx_cnt_q != {TXC_W{1'b0}}) begin
                sdo_d    = tx_q[DATA_W-1];
                tx_d     = {tx_q[DATA_W-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q - TXC_W'(1);
            end else begin
                sdo_d = 1'b0;
            end
        end else begin
            sdo_d = sdo_q;
        end
    end

    // Transmit registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q     <= {DATA_W{1'b0}};
            tx_cnt_q <= {TXC_W{1'b0}};
            sdo_q    <= 1'b0;
        end else begin
            tx_q     <= tx_d;
            tx_cnt_q <= tx_cnt_d;
            sdo_q    <= sdo_d;
        end
    end

    assign sdo_o = sdo_q;
`else
    assign sdo_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Scoreboard bench for spi_regfile: default instance A and a 16x16 instance B
// share sclk/sdi; each has its own chip select.
module tb_spi_regfile;

    localparam int K_WR  = 0;
    localparam int K_ERR = 1;
    localparam int K_RD  = 2;
`ifdef SPI_REGFILE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic sdi = 1'b0;
    logic cs_n_a = 1'b1;
    logic cs_n_b = 1'b1;

    logic         sdo_a, wr_stb_a, frame_err_a;
    logic [39:0]  regs_a;
    logic [6:0]   wr_addr_a;
    logic         sdo_b, wr_stb_b, frame_err_b;
    logic [255:0] regs_b;
    logic [3:0]   wr_addr_b;

    always #5 clk = ~clk;

    spi_regfile u_dut_a (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n_a), .sdi_i(sdi),
        .sdo_o(sdo_a), .regs_o(regs_a), .wr_stb_o(wr_stb_a),
        .wr_addr_o(wr_addr_a), .frame_err_o(frame_err_a)
    );

    spi_regfile #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .RESET_VAL(16'h0000)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n_b), .sdi_i(sdi),
        .sdo_o(sdo_b), .regs_o(regs_b), .wr_stb_o(wr_stb_b),
        .wr_addr_o(wr_addr_b), .frame_err_o(frame_err_b)
    );

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [31:0] rd_obs_a[$];
    logic [7:0]  mdl_a [5];
    logic [15:0] mdl_b [16];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    function automatic logic [39:0] flat_a();
        logic [39:0] v;
        for (int i = 0; i < 5; i++) v[i*8 +: 8] = mdl_a[i];
        return v;
    endfunction

    function automatic logic [255:0] flat_b();
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = mdl_b[i];
        return v;
    endfunction

    // Monitor A: pop an expectation whenever the DUT strobes or a read completes
    always @(negedge clk) begin : mon_a
        exp_t e;
        logic [31:0] obs;
        if (rst) begin
            for (int i = 0; i < 5; i++) mdl_a[i] = 8'h00;
        end else if (wr_stb_a || frame_err_a || rd_obs_a.size() != 0) begin
            obs = 32'h0;
            if (!wr_stb_a && !frame_err_a) obs = rd_obs_a.pop_front();
            chk("a_event_expected", 64'(exp_a.size() != 0), 64'd1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                if (wr_stb_a) begin
                    chk("a_kind_write", 64'(K_WR), 64'(e.kind));
                    chk("a_wr_addr", 64'(wr_addr_a), 64'(e.addr));
                    mdl_a[e.addr] = e.data[7:0];
                    chk("a_regs_after_write", 64'(regs_a), 64'(flat_a()));
                end else if (frame_err_a) begin
                    chk("a_kind_err", 64'(K_ERR), 64'(e.kind));
                    chk("a_regs_after_err", 64'(regs_a), 64'(flat_a()));
                end else begin
                    chk("a_kind_read", 64'(K_RD), 64'(e.kind));
                    chk("a_sdo_read", 64'(obs), 64'(e.data));
                    chk("a_regs_after_read", 64'(regs_a), 64'(flat_a()));
                end
            end
        end
    end

    // Monitor B: writes only
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 16; i++) mdl_b[i] = 16'h0000;
        end else if (wr_stb_b || frame_err_b) begin
            chk("b_event_expected", 64'(exp_b.size() != 0), 64'd1);
            chk("b_no_frame_err", 64'(frame_err_b), 64'd0);
            if (exp_b.size() != 0 && wr_stb_b) begin
                e = exp_b.pop_front();
                chk("b_wr_addr", 64'(wr_addr_b), 64'(e.addr));
                chk("b_reg_value", 64'(regs_b[e.addr*16 +: 16]), 64'(e.data));
                mdl_b[e.addr] = e.data[15:0];
                chk("b_regs_all", 64'(regs_b === flat_b()), 64'd1);
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cs(input bit sel_b, input logic v);
        if (sel_b) cs_n_b = v;
        else cs_n_a = v;
    endtask

    // Mode 0: sdi set while sclk low, sdo sampled just before each rise
    task automatic shift_bits(input bit sel_b, input logic [31:0] w, input int n,
                              output logic [31:0] cap);
        cap = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi = w[i];
            wclk(5);
            cap = {cap[30:0], (sel_b ? sdo_b : sdo_a)};
            sclk = 1'b1;
            wclk(5);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input bit sel_b, input logic [31:0] w, input int n, input int gap,
                         output logic [31:0] cap);
        set_cs(sel_b, 1'b0);
        wclk(5);
        shift_bits(sel_b, w, n, cap);
        wclk(5);
        set_cs(sel_b, 1'b1);
        sdi = 1'b0;
        wclk(gap);
    endtask

    task automatic expect_a(input int kind, input int addr, input logic [31:0] data);
        exp_a.push_back('{kind, addr, data});
    endtask

    task automatic expect_b(input int addr, input logic [31:0] data);
        exp_b.push_back('{K_WR, addr, data});
    endtask

    initial begin : stim
        logic [31:0] cap;
        wclk(3);
        rst = 1'b0;
        wclk(1);
        chk("rst_regs_a", 64'(regs_a), 64'd0);
        chk("rst_sdo_a", 64'(sdo_a), 64'd0);
        chk("rst_wr_stb_a", 64'(wr_stb_a), 64'd0);
        chk("rst_wr_addr_a", 64'(wr_addr_a), 64'd0);
        chk("rst_frame_err_a", 64'(frame_err_a), 64'd0);
        chk("rst_regs_b_zero", 64'(regs_b == 256'h0), 64'd1);

        // Write, read back, bad lengths, bad address, glitch
        expect_a(K_WR, 2, 32'hA5);
        frame(1'b0, 32'h82A5, 16, 20, cap);
        expect_a(K_RD, 0, RB ? 32'h0000_00A5 : 32'h0);
        frame(1'b0, 32'h0200, 16, 20, cap);
        rd_obs_a.push_back(cap);
        expect_a(K_ERR, 0, 32'h0);
        frame(1'b0, 32'h08A5, 12, 20, cap);
        expect_a(K_ERR, 0, 32'h0);
        frame(1'b0, 32'h1054B, 17, 20, cap);
        expect_a(K_ERR, 0, 32'h0);
        frame(1'b0, 32'h85FF, 16, 20, cap);
        expect_a(K_RD, 0, 32'h0);
        frame(1'b0, 32'h0500, 16, 20, cap);
        rd_obs_a.push_back(cap);
        expect_a(K_ERR, 0, 32'h0);
        cs_n_a = 1'b0;
        wclk(10);
        cs_n_a = 1'b1;
        wclk(20);

        // Reset in the middle of a write frame, then a clean write
        cs_n_a = 1'b0;
        wclk(5);
        shift_bits(1'b0, 32'h0105, 9, cap);
        rst = 1'b1;
        wclk(3);
        cs_n_a = 1'b1;
        sclk = 1'b0;
        sdi = 1'b0;
        wclk(2);
        rst = 1'b0;
        wclk(2);
        chk("rst_mid_regs_a", 64'(regs_a), 64'd0);
        chk("rst_mid_queue_a", 64'(exp_a.size()), 64'd0);
        expect_a(K_WR, 1, 32'h33);
        frame(1'b0, 32'h8133, 16, 20, cap);

        // Wide instance: top register, then back-to-back writes with a 2-clk gap
        expect_b(15, 32'hBEEF);
        frame(1'b1, 32'h1F_BEEF, 21, 20, cap);
        expect_b(1, 32'h1234);
        expect_b(3, 32'h5678);
        frame(1'b1, 32'h11_1234, 21, 2, cap);
        frame(1'b1, 32'h13_5678, 21, 20, cap);

        wclk(20);
        chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
        chk("a_reads_consumed", 64'(rd_obs_a.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        chk("a_final_regs", 64'(regs_a), 64'h00_0000_3300);
        chk("b_final_reg15", 64'(regs_b[15*16 +: 16]), 64'hBEEF);
        chk("b_final_reg3", 64'(regs_b[3*16 +: 16]), 64'h5678);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
